// File: rtl/mips_pkg.sv
// mips_pkg: shared widths, constants and the fetch buffer entry type used by
// the instruction fetch unit and its prefetch buffer.
//   INSTR_W / ADDR_W    : instruction word and byte-address widths
//   PC_INC              : sequential fetch stride in bytes
//   DEFAULT_RESET_PC    : default first fetch address after reset
//   fetch_entry_t       : {instr, pc} pair held in the prefetch buffer
//   align_pc()          : forces a byte address onto a word boundary
package mips_pkg;

   localparam int INSTR_W = 32;
   localparam int ADDR_W  = 32;

   localparam logic [ADDR_W-1:0] PC_INC           = 32'd4;
   localparam logic [ADDR_W-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

   typedef struct packed {
      logic [INSTR_W-1:0] instr;
      logic [ADDR_W-1:0]  pc;
   } fetch_entry_t;

   function automatic logic [ADDR_W-1:0] align_pc(input logic [ADDR_W-1:0] pc);
      return pc & ~ADDR_W'(3);
   endfunction

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: DEPTH-entry circular prefetch buffer.
//   clk, reset   : clock, asynchronous active-low reset
//   push         : write push_entry at the tail
//   push_entry   : {instr, pc} to store
//   pop          : retire the head entry
//   flush        : empty the buffer (wins over push and pop)
//   head         : entry at the head (content meaningless when count == 0)
//   count        : number of valid entries, 0..DEPTH
module fetch_fifo
   import mips_pkg::*;
#(
   parameter  int DEPTH = 2,
   localparam int CNT_W = $clog2(DEPTH + 1),
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  fetch_entry_t     push_entry,
   input  logic             pop,
   input  logic             flush,
   output fetch_entry_t     head,
   output logic [CNT_W-1:0] count
);

   fetch_entry_t     mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;

   // Pointers wrap explicitly so DEPTH need not be a power of two.
   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      if (p == PTR_W'(DEPTH - 1)) return '0;
      return p + PTR_W'(1);
   endfunction

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= push_entry;
            wr_ptr      <= ptr_inc(wr_ptr);
         end
         if (pop) rd_ptr <= ptr_inc(rd_ptr);
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   assign head = mem[rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: sequential instruction fetch with a credit-limited prefetch
// buffer and epoch-tagged redirect handling.
//   clk, reset      : clock, asynchronous active-low reset
//   imem_req/addr   : word-aligned read request to instruction memory
//   imem_rvalid/rdata : response, exactly one cycle after each request
//   instr_valid/ready : handshake towards IF/ID
//   instr_out/pc_out  : instruction word and its byte address at buffer head
//   redirect_valid/pc : branch/jump redirect; low two pc bits are ignored
module fetch_unit
   import mips_pkg::*;
#(
   parameter logic [ADDR_W-1:0] RESET_PC = DEFAULT_RESET_PC,
   parameter int                DEPTH    = 2
) (
   input  logic               clk,
   input  logic               reset,
   output logic               imem_req,
   output logic [ADDR_W-1:0]  imem_addr,
   input  logic               imem_rvalid,
   input  logic [INSTR_W-1:0] imem_rdata,
   output logic               instr_valid,
   input  logic               instr_ready,
   output logic [INSTR_W-1:0] instr_out,
   output logic [ADDR_W-1:0]  pc_out,
   input  logic               redirect_valid,
   input  logic [ADDR_W-1:0]  redirect_pc
);

   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam int CRD_W = CNT_W + 1;

   logic [ADDR_W-1:0] fetch_pc;
   logic              outstanding;
   logic              epoch;
   logic [ADDR_W-1:0] req_pc_p1;
   logic              req_epoch_p1;

   logic [CNT_W-1:0]  count;
   logic [CRD_W-1:0]  credit_used;
   logic              pop;
   logic              push;
   fetch_entry_t      push_entry;
   fetch_entry_t      head;

   always_comb begin
      instr_valid = 1'b0;
      pop         = 1'b0;
      credit_used = '0;
      imem_req    = 1'b0;
      push        = 1'b0;
      push_entry  = '0;

      // A redirect hides the head, so any pop in that cycle is void.
      instr_valid = (count != '0) && !redirect_valid;
      pop         = instr_valid && instr_ready;

      // Slots already promised: buffered entries plus the one in flight,
      // minus the slot freed this cycle. Keeps count <= DEPTH.
      credit_used = CRD_W'(count) + CRD_W'(outstanding) - CRD_W'(pop);

      // Gated by reset so nothing is requested while reset is held.
      imem_req = reset && !redirect_valid && (credit_used < CRD_W'(DEPTH));

      // Only the response to a live request from the current epoch is kept;
      // one landing in a redirect cycle belongs to the abandoned stream.
      push             = imem_rvalid && outstanding && (req_epoch_p1 == epoch) && !redirect_valid;
      push_entry.instr = imem_rdata;
      push_entry.pc    = req_pc_p1;
   end

   // ---- request stage -> response stage ----
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         fetch_pc     <= RESET_PC;
         outstanding  <= 1'b0;
         epoch        <= 1'b0;
         req_pc_p1    <= '0;
         req_epoch_p1 <= 1'b0;
      end else begin
         outstanding <= imem_req || (outstanding && !imem_rvalid);
         if (imem_req) begin
            req_pc_p1    <= fetch_pc;
            req_epoch_p1 <= epoch;
         end
         if (redirect_valid) begin
            epoch    <= ~epoch;
            fetch_pc <= align_pc(redirect_pc);
         end else if (imem_req) begin
            fetch_pc <= fetch_pc + PC_INC;
         end
      end
   end

   // ---- response stage -> buffer head ----
   fetch_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk        (clk),
      .reset      (reset),
      .push       (push),
      .push_entry (push_entry),
      .pop        (pop),
      .flush      (redirect_valid),
      .head       (head),
      .count      (count)
   );

   assign imem_addr = fetch_pc;
   assign instr_out = head.instr;
   assign pc_out    = head.pc;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        instr_ready;
   logic        redirect_valid;
   logic [31:0] redirect_pc;

   // main instance
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        mem_rvalid = 1'b0;
   logic [31:0] mem_rdata  = 32'h0;
   logic        instr_valid;
   logic [31:0] instr_out;
   logic [31:0] pc_out;

   // wrap-around instance
   logic        w_req;
   logic [31:0] w_addr;
   logic        w_rvalid = 1'b0;
   logic [31:0] w_rdata  = 32'h0;
   logic        w_valid;
   logic [31:0] w_instr;
   logic [31:0] w_pc;

   int n_cmp   = 0;
   int n_err   = 0;
   int req_cnt = 0;
   int cnt0;

   always #5 clk = ~clk;

   fetch_unit u_dut (
      .clk            (clk),
      .reset          (reset),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_rvalid    (mem_rvalid),
      .imem_rdata     (mem_rdata),
      .instr_valid    (instr_valid),
      .instr_ready    (instr_ready),
      .instr_out      (instr_out),
      .pc_out         (pc_out),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc)
   );

   fetch_unit #(
      .RESET_PC (32'hFFFF_FFF8)
   ) u_wrap (
      .clk            (clk),
      .reset          (reset),
      .imem_req       (w_req),
      .imem_addr      (w_addr),
      .imem_rvalid    (w_rvalid),
      .imem_rdata     (w_rdata),
      .instr_valid    (w_valid),
      .instr_ready    (1'b1),
      .instr_out      (w_instr),
      .pc_out         (w_pc),
      .redirect_valid (1'b0),
      .redirect_pc    (32'h0)
   );

   // One-cycle memory: data = addr ^ A5A5_0000. Deliberately not reset, so a
   // response issued just before a reset pulse still arrives afterwards.
   always @(posedge clk) begin
      mem_rvalid <= imem_req;
      mem_rdata  <= imem_addr ^ 32'hA5A5_0000;
      w_rvalid   <= w_req;
      w_rdata    <= w_addr ^ 32'hA5A5_0000;
      if (imem_req) req_cnt <= req_cnt + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   // inputs change at the falling edge, outputs sampled 1 time unit later
   task automatic step();
      @(negedge clk);
   endtask

   task automatic settle();
      #1;
   endtask

   initial begin
      reset = 1'b0; instr_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0;

      // reset state
      step(); settle();
      chk1("rst_req",   imem_req,    1'b0);
      chk1("rst_valid", instr_valid, 1'b0);
      chk ("rst_instr", instr_out,   32'h0);
      chk ("rst_pc",    pc_out,      32'h0);
      chk ("rst_addr",  imem_addr,   32'h0);
      chk ("rst_waddr", w_addr,      32'hFFFF_FFF8);
      chk1("rst_wreq",  w_req,       1'b0);

      // streaming after reset release, ready held high
      step(); reset = 1'b1; settle();
      chk1("a0_req",   imem_req,    1'b1);
      chk ("a0_addr",  imem_addr,   32'h0);
      chk1("a0_valid", instr_valid, 1'b0);
      step(); settle();
      chk1("a1_req",   imem_req,    1'b1);
      chk ("a1_addr",  imem_addr,   32'h4);
      chk1("a1_valid", instr_valid, 1'b0);
      step(); settle();
      chk1("a2_valid", instr_valid, 1'b1);
      chk ("a2_pc",    pc_out,      32'h0);
      chk ("a2_instr", instr_out,   32'hA5A5_0000);
      chk ("a2_addr",  imem_addr,   32'h8);
      chk ("a2_wpc",   w_pc,        32'hFFFF_FFF8);
      chk ("a2_waddr", w_addr,      32'h0);
      step(); settle();
      chk1("a3_valid", instr_valid, 1'b1);
      chk ("a3_pc",    pc_out,      32'h4);
      chk ("a3_instr", instr_out,   32'hA5A5_0004);
      chk ("a3_wpc",   w_pc,        32'hFFFF_FFFC);
      step(); settle();
      chk ("a4_pc",    pc_out,      32'h8);
      chk ("a4_wpc",   w_pc,        32'h0);
      chk ("a4_winstr", w_instr,    32'hA5A5_0000);
      step(); settle();
      chk ("a5_pc",    pc_out,      32'hC);

      // back-pressure from an empty buffer
      step(); reset = 1'b0;
      step(); reset = 1'b1; instr_ready = 1'b0; cnt0 = req_cnt; settle();
      chk1("b0_req",   imem_req,    1'b1);
      chk ("b0_addr",  imem_addr,   32'h0);
      step(); settle();
      chk1("b1_req",   imem_req,    1'b1);
      chk ("b1_addr",  imem_addr,   32'h4);
      chk1("b1_valid", instr_valid, 1'b0);
      step(); settle();
      chk1("b2_req",   imem_req,    1'b0);
      chk1("b2_valid", instr_valid, 1'b1);
      chk ("b2_pc",    pc_out,      32'h0);
      step(); settle();
      chk1("b3_req",   imem_req,    1'b0);
      chk ("b3_pc",    pc_out,      32'h0);
      step(); settle();
      chk1("b4_req",   imem_req,    1'b0);
      chk ("b4_pc",    pc_out,      32'h0);
      chk ("b4_instr", instr_out,   32'hA5A5_0000);
      step(); instr_ready = 1'b1; settle();
      chk ("b_req_count", 32'(req_cnt - cnt0), 32'd2);
      chk1("b5_valid", instr_valid, 1'b1);
      chk ("b5_pc",    pc_out,      32'h0);
      chk1("b5_req",   imem_req,    1'b1);
      chk ("b5_addr",  imem_addr,   32'h8);
      step(); settle();
      chk ("b6_pc",    pc_out,      32'h4);
      step(); settle();
      chk ("b7_pc",    pc_out,      32'h8);

      // redirect with one entry buffered and one response in flight
      step(); redirect_valid = 1'b1; redirect_pc = 32'h0000_0103; settle();
      chk1("c0_valid", instr_valid, 1'b0);
      chk1("c0_req",   imem_req,    1'b0);
      step(); redirect_valid = 1'b0; settle();
      chk1("c1_req",   imem_req,    1'b1);
      chk ("c1_addr",  imem_addr,   32'h0000_0100);
      chk1("c1_valid", instr_valid, 1'b0);
      step(); settle();
      chk1("c2_valid", instr_valid, 1'b0);
      chk ("c2_addr",  imem_addr,   32'h0000_0104);
      step(); settle();
      chk1("c3_valid", instr_valid, 1'b1);
      chk ("c3_pc",    pc_out,      32'h0000_0100);
      chk ("c3_instr", instr_out,   32'hA5A5_0100);
      step(); settle();
      chk ("c4_pc",    pc_out,      32'h0000_0104);

      // back-to-back redirects: the later one wins
      step(); redirect_valid = 1'b1; redirect_pc = 32'h40; settle();
      chk1("d0_valid", instr_valid, 1'b0);
      chk1("d0_req",   imem_req,    1'b0);
      step(); redirect_pc = 32'h80; settle();
      chk1("d1_valid", instr_valid, 1'b0);
      chk1("d1_req",   imem_req,    1'b0);
      step(); redirect_valid = 1'b0; settle();
      chk1("d2_req",   imem_req,    1'b1);
      chk ("d2_addr",  imem_addr,   32'h80);
      chk1("d2_valid", instr_valid, 1'b0);
      step(); settle();
      chk1("d3_valid", instr_valid, 1'b0);
      chk ("d3_addr",  imem_addr,   32'h84);
      step(); settle();
      chk1("d4_valid", instr_valid, 1'b1);
      chk ("d4_pc",    pc_out,      32'h80);
      step(); settle();
      chk ("d5_pc",    pc_out,      32'h84);

      // half-cycle reset pulse while a response is in flight
      @(posedge clk); #2 reset = 1'b0; #1;
      chk1("e_rst_req",   imem_req,    1'b0);
      chk1("e_rst_valid", instr_valid, 1'b0);
      chk ("e_rst_instr", instr_out,   32'h0);
      chk ("e_rst_pc",    pc_out,      32'h0);
      chk ("e_rst_addr",  imem_addr,   32'h0);
      chk ("e_rst_wpc",   w_pc,        32'h0);
      chk ("e_rst_waddr", w_addr,      32'hFFFF_FFF8);
      #4 reset = 1'b1; #1;
      chk1("e0_req",   imem_req,    1'b1);
      chk ("e0_addr",  imem_addr,   32'h0);
      chk1("e0_valid", instr_valid, 1'b0);
      step(); settle();
      chk1("e1_valid", instr_valid, 1'b0);
      chk ("e1_addr",  imem_addr,   32'h4);
      step(); settle();
      chk1("e2_valid", instr_valid, 1'b1);
      chk ("e2_pc",    pc_out,      32'h0);
      chk ("e2_instr", instr_out,   32'hA5A5_0000);
      step(); settle();
      chk ("e3_pc",    pc_out,      32'h4);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-002 Parameter DEPTH, default 2: prefetch buffer entries; also the maximum number of outstanding requests.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-low; 0 resets all state immediately.
REQ-005 imem_req  output  1  instruction memory read request this cycle.
REQ-006 imem_addr  output  32  byte address of the request; bits [1:0] are always 0.
REQ-007 imem_rvalid  input  1  read data valid; asserted exactly 1 cycle after each imem_req, in order.
REQ-008 imem_rdata  input  32  instruction word returned with imem_rvalid.
REQ-009 instr_valid  output  1  instr_out and pc_out hold a valid instruction for IF/ID.
REQ-010 instr_ready  input  1  IF/ID accepts; a transfer occurs when instr_valid and instr_ready are both 1.
REQ-011 instr_out  output  32  instruction word at the buffer head.
REQ-012 pc_out  output  32  byte address of instr_out.
REQ-013 redirect_valid  input  1  branch/jump redirect from a downstream stage.
REQ-014 redirect_pc  input  32  redirect target; bits [1:0] are ignored and treated as 0.

Function
REQ-015 fetch_pc register; after each issued request, fetch_pc <= fetch_pc + 4, modulo 2^32 (32'hFFFF_FFFC wraps to 0).
REQ-016 imem_addr = fetch_pc; imem_req = 1 iff (count + outstanding - pop) < DEPTH and redirect_valid = 0.
- pop = instr_valid & instr_ready.
REQ-017 outstanding (0..1) is set the cycle after a request is issued and clears on the matching imem_rvalid.
REQ-018 Each accepted imem_rvalid pushes {imem_rdata, request address} into the buffer; the entry is visible at the head on the next cycle.
REQ-019 Latency: a request in cycle N produces imem_rvalid in N+1 and instr_valid in N+2 (buffer previously empty).
REQ-020 Throughput: with instr_ready held at 1, one instruction is delivered per cycle in steady state.
REQ-021 instr_valid = (count > 0) & ~redirect_valid.
REQ-022 instr_out and pc_out remain stable while instr_valid = 1 and instr_ready = 0.
REQ-023 Buffer order is FIFO. A simultaneous push and pop is allowed at any count. The credit rule guarantees count <= DEPTH, so overflow cannot occur.
REQ-024 Redirect cycle behaviour:
- the buffer is emptied;
- fetch_pc <= {redirect_pc[31:2], 2'b00};
- no request is issued;
- any pop in the same cycle is void.
REQ-025 An epoch bit toggles on each redirect. Responses tagged with the old epoch (in flight during the redirect) are dropped and not pushed.
REQ-026 First post-redirect request is issued the cycle after redirect_valid, to address redirect_pc.
REQ-027 Back-to-back redirects: the last one wins; every intermediate in-flight response is dropped.
REQ-028 imem_rvalid with no outstanding request is ignored.

Reset
REQ-029 While reset = 0:
- fetch_pc = RESET_PC; count = 0; outstanding = 0; epoch = 0;
- imem_req = 0; instr_valid = 0; instr_out = 0; pc_out = 0.
REQ-030 First request (address RESET_PC) is issued on the first rising edge after reset deasserts.
REQ-031 Reset asserted mid-operation discards the buffer and any in-flight response. A response arriving on the first post-reset cycle is ignored.

Structure
REQ-032 Shared package mips_pkg holds: INSTR_W = 32, ADDR_W = 32, PC_INC = 4, the default RESET_PC, and the fetch entry struct {instr, pc}.
REQ-033 Sub-module fetch_fifo: parameterised DEPTH circular buffer with count, push, pop and flush. fetch_unit holds the PC, credit and epoch logic.

Verification
REQ-034 Reset release, instr_ready = 1, memory returns addr ^ 32'hA5A5_0000:
- first instr_valid two cycles after the first req with pc_out = 0;
- then pc_out = 4, 8, 12 on consecutive cycles.
REQ-035 instr_ready = 0 for 5 cycles, starting with the buffer empty:
- exactly 2 requests issued, imem_req then stays 0;
- head holds pc_out = 0;
- on release, pc_out 0, 4, 8 are delivered with no gap or duplicate.
REQ-036 redirect_valid = 1, redirect_pc = 32'h0000_0103, while one request is in flight and 1 entry is buffered:
- instr_valid = 0 that cycle;
- stale response dropped;
- next req addr = 32'h0000_0100;
- next delivered pc_out = 32'h0000_0100.
REQ-037 RESET_PC = 32'hFFFF_FFF8: delivered pc_out sequence is FFFF_FFF8, FFFF_FFFC, 0000_0000.
REQ-038 Redirects in two consecutive cycles (0x40 then 0x80): no instruction from 0x40 is delivered; first pc_out = 0x80.
REQ-039 reset pulsed low for one half-cycle mid-stream: outputs clear immediately; fetch restarts at RESET_PC with no stale entry.
